// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared micro-architecture types for the dispatch scoreboard.
//   eu_class_e : execution-unit class encoding carried on slot_class
//   reg_num_t  : architectural register index sized from the default register count
//   slot_t     : per-slot decode bundle, kept for future packing of the slot ports
package core_dispatch_scoreboard_pkg;

  typedef enum logic [1:0] {
    EU_ALU    = 2'd0,
    EU_BRANCH = 2'd1,
    EU_LDST   = 2'd2,
    EU_MUL    = 2'd3
  } eu_class_e;

  localparam int NREGS_DEFAULT = 16;
  localparam int REG_BITS      = $clog2(NREGS_DEFAULT);

  typedef logic [REG_BITS-1:0] reg_num_t;

  typedef struct packed {
    logic      valid;
    logic      execute;
    eu_class_e cls;
    logic      writeback;
    reg_num_t  rd;
    reg_num_t  ra;
    reg_num_t  rb;
    logic      uses_ra;
    logic      uses_rb;
  } slot_t;

endpackage

// File: rtl/core_dispatch_scoreboard_regs.sv
// Register busy file for the dispatch scoreboard.
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : discard all busy state (and any same-cycle set)
//   wb_valid/wb_rd : writeback ports, each clears one busy bit
//   set_mask       : registers claimed by this cycle's dispatched producers
//   busy           : registered busy state
//   eb             : busy with this cycle's writebacks already removed (bypass view)
module core_dispatch_scoreboard_regs #(
  parameter  int NREGS = 16,
  parameter  int NWB   = 2,
  localparam int RB    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [RB*NWB-1:0] wb_rd,
  input  logic [NREGS-1:0]  set_mask,
  output logic [NREGS-1:0]  busy,
  output logic [NREGS-1:0]  eb
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] cleared;

  always_comb begin
    cleared = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p]) cleared[wb_rd[p*RB +: RB]] = 1'b1;
    end
  end

  assign eb = busy_q & ~cleared;

  // Set is ORed after the clear so a same-cycle re-claim wins.
  always_comb begin
    busy_d = flush ? '0 : (eb | set_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// N-wide in-order dispatch gate with register scoreboard.
//   slot_*          : decoded issue group, slot 0 oldest
//   wb_valid/wb_rd  : writebacks clearing busy bits (bypassed same cycle)
//   class_ready     : per-class unit availability
//   branch_stall    : blocks all dispatch
//   flush           : clears the scoreboard
//   dispatch        : combinational per-slot grant (always an in-order prefix)
//   busy            : registered scoreboard state
//   stall_cycles    : saturating count of cycles with slot 0 valid but held
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int NREGS    = 16,
  parameter  int NWB      = 2,
  parameter  int N_ALU    = 2,
  parameter  int N_BRANCH = 1,
  parameter  int N_LDST   = 1,
  parameter  int N_MUL    = 1,
  localparam int RB       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [WIDTH-1:0]    slot_valid,
  input  logic [WIDTH-1:0]    slot_execute,
  input  logic [2*WIDTH-1:0]  slot_class,
  input  logic [WIDTH-1:0]    slot_writeback,
  input  logic [RB*WIDTH-1:0] slot_rd,
  input  logic [RB*WIDTH-1:0] slot_ra,
  input  logic [RB*WIDTH-1:0] slot_rb,
  input  logic [WIDTH-1:0]    slot_uses_ra,
  input  logic [WIDTH-1:0]    slot_uses_rb,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [RB*NWB-1:0]   wb_rd,
  input  logic [3:0]          class_ready,
  input  logic                branch_stall,
  output logic [WIDTH-1:0]    dispatch,
  output logic [NREGS-1:0]    busy,
  output logic [31:0]         stall_cycles
);

  logic [NREGS-1:0] eb;
  logic [NREGS-1:0] set_mask;
  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] grant;
  logic [31:0]      stall_cycles_q;
  logic [31:0]      stall_cycles_d;

  core_dispatch_scoreboard_regs #(
    .NREGS (NREGS),
    .NWB   (NWB)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .set_mask (set_mask),
    .busy     (busy),
    .eb       (eb)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      logic [RB-1:0] my_rd, my_ra, my_rb;
      eu_class_e     my_cls;
      logic          hazard;
      int            cls_cnt;
      int            cls_lim;
      logic          elig;

      assign my_rd  = slot_rd[gi*RB +: RB];
      assign my_ra  = slot_ra[gi*RB +: RB];
      assign my_rb  = slot_rb[gi*RB +: RB];
      assign my_cls = eu_class_e'(slot_class[gi*2 +: 2]);

      // Earlier slots are treated as granted: if any of them is not,
      // the prefix rule drops this slot anyway.
      always_comb begin
        logic [RB-1:0] rd_j;
        rd_j    = '0;
        hazard  = 1'b0;
        cls_cnt = 1;
        if (slot_uses_ra[gi] && eb[my_ra])     hazard = 1'b1;
        if (slot_uses_rb[gi] && eb[my_rb])     hazard = 1'b1;
        if (slot_writeback[gi] && eb[my_rd])   hazard = 1'b1;
        for (int j = 0; j < gi; j++) begin
          if (slot_valid[j] && slot_execute[j]) begin
            rd_j = slot_rd[j*RB +: RB];
            if (slot_writeback[j] &&
                ((slot_uses_ra[gi] && rd_j == my_ra) ||
                 (slot_uses_rb[gi] && rd_j == my_rb) ||
                 (slot_writeback[gi] && rd_j == my_rd)))
              hazard = 1'b1;
            if (eu_class_e'(slot_class[j*2 +: 2]) == my_cls) cls_cnt = cls_cnt + 1;
          end
        end
      end

      always_comb begin
        case (my_cls)
          EU_ALU:    cls_lim = N_ALU;
          EU_BRANCH: cls_lim = N_BRANCH;
          EU_LDST:   cls_lim = N_LDST;
          default:   cls_lim = N_MUL;
        endcase
      end

      // No-op slots (execute=0) bypass every hazard and structural check.
      always_comb begin
        elig = slot_valid[gi] &&
               (!slot_execute[gi] ||
                (!hazard && (cls_cnt <= cls_lim) && class_ready[my_cls]));
      end

      assign eligible[gi] = elig;
    end
  endgenerate

  always_comb begin
    logic run;
    run   = !branch_stall;
    grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run      = run && eligible[i];
      grant[i] = run;
    end
  end

  assign dispatch = grant;

  always_comb begin
    set_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant[i] && slot_execute[i] && slot_writeback[i])
        set_mask[slot_rd[i*RB +: RB]] = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (slot_valid[0] && !grant[0] && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
module tb_core_dispatch_scoreboard;
  localparam int W   = 2;
  localparam int NR  = 16;
  localparam int NWB = 2;
  localparam int RB  = 4;
  localparam int LIM [4] = '{2, 1, 1, 1};

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [W-1:0]    slot_valid, slot_execute, slot_writeback, slot_uses_ra, slot_uses_rb;
  logic [2*W-1:0]  slot_class;
  logic [RB*W-1:0] slot_rd, slot_ra, slot_rb;
  logic [NWB-1:0]  wb_valid;
  logic [RB*NWB-1:0] wb_rd;
  logic [3:0]      class_ready;
  logic            branch_stall;
  logic [W-1:0]    dispatch;
  logic [NR-1:0]   busy;
  logic [31:0]     stall_cycles;

  always #10 clk = ~clk;

  core_dispatch_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .slot_valid(slot_valid), .slot_execute(slot_execute), .slot_class(slot_class),
    .slot_writeback(slot_writeback), .slot_rd(slot_rd), .slot_ra(slot_ra), .slot_rb(slot_rb),
    .slot_uses_ra(slot_uses_ra), .slot_uses_rb(slot_uses_rb),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .class_ready(class_ready),
    .branch_stall(branch_stall), .dispatch(dispatch), .busy(busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [W-1:0]  disp;
    logic [NR-1:0] busy;
    logic [31:0]   stall;
    int            want;
    int            id;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          txn = 0;
  bit          m_busy[NR];
  logic [31:0] m_stall;

  // Monitor: pops one expectation per presented transaction and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        total += 3;
        if (dispatch !== e.disp) begin
          bad++; $display("FAIL dispatch txn=%0d got=%b exp=%b", e.id, dispatch, e.disp);
        end
        if (busy !== e.busy) begin
          bad++; $display("FAIL busy txn=%0d got=%h exp=%h", e.id, busy, e.busy);
        end
        if (stall_cycles !== e.stall) begin
          bad++; $display("FAIL stall_cycles txn=%0d got=%h exp=%h", e.id, stall_cycles, e.stall);
        end
        if (e.want >= 0) begin
          total++;
          if (dispatch !== W'(e.want)) begin
            bad++; $display("FAIL directed_dispatch txn=%0d got=%b exp=%b", e.id, dispatch, W'(e.want));
          end
        end
        $display("txn %0d dispatch=%b busy=%h stall=%0d", e.id, dispatch, busy, stall_cycles);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    flush = 0; slot_valid = '0; slot_execute = '0; slot_class = '0; slot_writeback = '0;
    slot_rd = '0; slot_ra = '0; slot_rb = '0; slot_uses_ra = '0; slot_uses_rb = '0;
    wb_valid = '0; wb_rd = '0; class_ready = 4'hF; branch_stall = 0;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic set_slot(input int i, input bit ex, input int cls, input bit wb, input int rd,
                          input bit ua, input int ra, input bit ub, input int rb);
    slot_valid[i] = 1'b1; slot_execute[i] = ex; slot_class[i*2 +: 2] = 2'(cls);
    slot_writeback[i] = wb; slot_rd[i*RB +: RB] = RB'(rd);
    slot_uses_ra[i] = ua; slot_ra[i*RB +: RB] = RB'(ra);
    slot_uses_rb[i] = ub; slot_rb[i*RB +: RB] = RB'(rb);
  endtask

  task automatic set_wb(input int p, input int rd);
    wb_valid[p] = 1'b1; wb_rd[p*RB +: RB] = RB'(rd);
  endtask

  // Reference model: walks the group oldest-first, granting until the first
  // slot that cannot go. Writes granted earlier in the group are tracked in wr.
  task automatic cyc_end(input int want);
    bit   eb[NR];
    bit   wr[NR];
    int   cnt[4];
    logic [W-1:0] d;
    bit   go, ok;
    int   c, rd, ra, rb;
    exp_t e;
    #1;
    for (int r = 0; r < NR; r++) begin eb[r] = m_busy[r]; wr[r] = 0; end
    for (int p = 0; p < NWB; p++) if (wb_valid[p]) eb[wb_rd[p*RB +: RB]] = 0;
    cnt = '{0, 0, 0, 0};
    d = '0;
    go = !branch_stall;
    for (int i = 0; i < W; i++) begin
      c  = int'(slot_class[i*2 +: 2]);
      rd = int'(slot_rd[i*RB +: RB]);
      ra = int'(slot_ra[i*RB +: RB]);
      rb = int'(slot_rb[i*RB +: RB]);
      if (!go || !slot_valid[i]) go = 0;
      else if (!slot_execute[i]) d[i] = 1;
      else begin
        ok = 1;
        if (slot_uses_ra[i] && (eb[ra] || wr[ra])) ok = 0;
        if (slot_uses_rb[i] && (eb[rb] || wr[rb])) ok = 0;
        if (slot_writeback[i] && (eb[rd] || wr[rd])) ok = 0;
        if (cnt[c] + 1 > LIM[c]) ok = 0;
        if (!class_ready[c]) ok = 0;
        if (ok) begin
          d[i] = 1; cnt[c]++;
          if (slot_writeback[i]) wr[rd] = 1;
        end else go = 0;
      end
    end
    e.disp = d; e.stall = m_stall; e.want = want; e.id = txn;
    for (int r = 0; r < NR; r++) e.busy[r] = m_busy[r];
    q.push_back(e);
    txn++;
    if (slot_valid[0] && !d[0] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    for (int r = 0; r < NR; r++) m_busy[r] = flush ? 1'b0 : (eb[r] | wr[r]);
  endtask

  // Asynchronous reset pulse placed between clock edges after an idle cycle.
  task automatic mid_reset();
    cyc_begin();
    cyc_end(0);
    #3;
    rst = 1;
    #1;
    total += 2;
    if (busy !== '0) begin bad++; $display("FAIL async_reset_busy got=%h exp=0", busy); end
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL async_reset_stall got=%h exp=0", stall_cycles); end
    #1;
    rst = 0;
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    m_stall = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    m_stall = 0;
    #5;
    total += 3;
    if (busy !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    if (stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall_cycles); end
    if (dispatch !== '0) begin bad++; $display("FAIL reset_dispatch got=%b exp=0", dispatch); end
    @(negedge clk); #4; rst = 0;

    // 1: intra-group RAW on r3
    cyc_begin(); set_slot(0, 1, 0, 1, 3, 0, 0, 0, 0); set_slot(1, 1, 0, 0, 0, 1, 3, 0, 0); cyc_end(1);
    // 2: set r5, then consumer bypassed by same-cycle writeback (also clear r3)
    cyc_begin(); set_slot(0, 1, 0, 1, 5, 0, 0, 0, 0); cyc_end(1);
    cyc_begin(); set_slot(0, 1, 0, 0, 0, 1, 5, 0, 0); set_wb(0, 5); set_wb(1, 3); cyc_end(1);
    cyc_begin(); cyc_end(0);
    // 3: LDST structural limit, MUL unit not ready
    cyc_begin(); set_slot(0, 1, 2, 1, 8, 0, 0, 0, 0); set_slot(1, 1, 2, 1, 9, 0, 0, 0, 0); cyc_end(1);
    cyc_begin(); set_slot(0, 1, 3, 0, 0, 0, 0, 0, 0); set_slot(1, 1, 3, 0, 0, 0, 0, 0, 0);
    class_ready = 4'b0111; cyc_end(0);
    // 4: no-op slot reading busy r7 does not block
    cyc_begin(); set_slot(0, 1, 0, 1, 7, 0, 0, 0, 0); cyc_end(1);
    cyc_begin(); set_slot(0, 0, 0, 1, 12, 1, 7, 0, 0); set_slot(1, 1, 0, 1, 10, 0, 0, 0, 0); cyc_end(3);
    cyc_begin(); cyc_end(0);
    // 5: set beats clear on r2, then flush discards everything
    cyc_begin(); set_slot(0, 1, 0, 1, 2, 0, 0, 0, 0); set_wb(0, 2); cyc_end(1);
    cyc_begin(); cyc_end(0);
    cyc_begin(); set_slot(0, 1, 0, 1, 11, 0, 0, 0, 0); flush = 1; cyc_end(1);
    cyc_begin(); cyc_end(0);
    // 6: stall with busy nonzero, async reset, then saturation
    cyc_begin(); set_slot(0, 1, 0, 1, 4, 0, 0, 0, 0); cyc_end(1);
    cyc_begin(); set_slot(0, 1, 1, 0, 0, 0, 0, 0, 0); class_ready = 4'b0000; cyc_end(0);
    mid_reset();
    cyc_begin();
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    cyc_end(0);
    release dut.stall_cycles_q;
    for (int k = 0; k < 3; k++) begin
      cyc_begin(); set_slot(0, 1, 0, 0, 0, 0, 0, 0, 0); class_ready = 4'b0000; cyc_end(0);
    end
    cyc_begin(); cyc_end(0);
    mid_reset();

    // Randomized traffic on a narrow register range to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      cyc_begin();
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) != 0)
          set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7));
      end
      for (int p = 0; p < NWB; p++) if ($urandom_range(0, 1) == 1) set_wb(p, $urandom_range(0, 7));
      for (int b = 0; b < 4; b++) class_ready[b] = ($urandom_range(0, 4) != 0);
      branch_stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      cyc_end(-1);
    end

    cyc_begin(); cyc_end(0);
    @(negedge clk); #5;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
